// File: rtl/mem_line_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_line_responder_pkg
// Brief   : Shared constants for the cache-miss line responder.
// Revision: 1.0 - initial release
// ============================================================================
package mem_line_responder_pkg;

  localparam int MEMRSP_ADDR_W      = 32;
  localparam int MEMRSP_DATA_W      = 32;
  localparam int MEMRSP_LINE_WORDS  = 4;
  localparam int MEMRSP_LATENCY     = 3;
  localparam int MEMRSP_DEPTH_WORDS = 1024;

  localparam logic [2:0] MEMRSP_ST_IDLE     = 3'd0;
  localparam logic [2:0] MEMRSP_ST_LAT      = 3'd1;
  localparam logic [2:0] MEMRSP_ST_RD_BURST = 3'd2;
  localparam logic [2:0] MEMRSP_ST_WR_BURST = 3'd3;
  localparam logic [2:0] MEMRSP_ST_WR_DONE  = 3'd4;

  localparam logic RSP_ID_I = 1'b0;
  localparam logic RSP_ID_D = 1'b1;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_line_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_line_responder_if
// Brief   : Cache-side request, write-back and response bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_line_responder_if
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W = MEMRSP_ADDR_W,
  parameter int DATA_W = MEMRSP_DATA_W
);
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              o_i_req_ready;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic              o_d_req_ready;
  logic [DATA_W-1:0] d_wdata;
  logic              d_wdata_valid;
  logic              o_d_wdata_ready;
  logic              o_rsp_valid;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_id;
  logic              o_rsp_last;
  logic              o_wr_done;

  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we,
           d_wdata, d_wdata_valid,
    input  o_i_req_ready, o_d_req_ready, o_d_wdata_ready, o_rsp_valid,
           o_rsp_data, o_rsp_id, o_rsp_last, o_wr_done
  );

  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, d_req_we,
           d_wdata, d_wdata_valid,
    output o_i_req_ready, o_d_req_ready, o_d_wdata_ready, o_rsp_valid,
           o_rsp_data, o_rsp_id, o_rsp_last, o_wr_done
  );

endinterface
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_word_array
// Brief   : Single-port word storage, synchronous read, no reset.
// Revision: 1.0 - initial release
// ============================================================================
module mem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_W      = 32,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
    rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_line_responder
// Brief   : Arbitrates I/D cache line refills and write-backs over one store.
// Revision: 1.0 - initial release
// ============================================================================
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W      = MEMRSP_ADDR_W,
  parameter int DATA_W      = MEMRSP_DATA_W,
  parameter int LINE_WORDS  = MEMRSP_LINE_WORDS,
  parameter int LATENCY     = MEMRSP_LATENCY,
  parameter int DEPTH_WORDS = MEMRSP_DEPTH_WORDS
) (
  input  logic                Clk,
  input  logic                Rst,
  mem_line_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = $clog2(LINE_WORDS);
  localparam int CW = clog2_min1(LATENCY);
  localparam logic [LW-1:0] LAST_BEAT   = LW'(LINE_WORDS - 1);
  localparam logic [LW-1:0] PENULT_BEAT = LW'(LINE_WORDS - 2);
  localparam logic [CW-1:0] LAT_LOAD    = CW'(LATENCY - 1);
  localparam logic [AW-1:0] LINE_MASK   = ~AW'(LINE_WORDS - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] lat_cnt_q, lat_cnt_d;
  logic [LW-1:0] beat_q, beat_d;
  logic [AW-1:0] base_q, base_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic          last_conflict_d_q, last_conflict_d_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic          rsp_last_q, rsp_last_d;
  logic          wr_done_q, wr_done_d;

  logic [ADDR_W-1:0] w_i_addr, w_d_addr;
  logic [AW-1:0]     w_i_line, w_d_line;
  logic [AW-1:0]     w_beat_ext, w_mem_addr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_idle, w_both, w_grant_i, w_grant_d;
  logic              w_wr_burst, w_lat_done, w_mem_we;
  logic              w_unused_addr;

  assign w_i_addr = bus.i_req_addr;
  assign w_d_addr = bus.d_req_addr;
  assign w_i_line = w_i_addr[AW+1:2] & LINE_MASK;
  assign w_d_line = w_d_addr[AW+1:2] & LINE_MASK;
  assign w_unused_addr = ^{w_i_addr, w_d_addr};

  // D wins a conflict unless it also won the previous one.
  assign w_idle     = (state_q == MEMRSP_ST_IDLE);
  assign w_both     = bus.i_req_valid && bus.d_req_valid;
  assign w_grant_d  = bus.d_req_valid && (!bus.i_req_valid || !last_conflict_d_q);
  assign w_grant_i  = bus.i_req_valid && !w_grant_d;
  assign w_wr_burst = (state_q == MEMRSP_ST_WR_BURST);
  assign w_lat_done = (state_q == MEMRSP_ST_LAT) && (lat_cnt_q == '0);

  assign bus.o_i_req_ready   = !Rst && w_idle && w_grant_i;
  assign bus.o_d_req_ready   = !Rst && w_idle && w_grant_d;
  assign bus.o_d_wdata_ready = !Rst && w_wr_burst;

  always_comb begin
    state_d           = state_q;
    lat_cnt_d         = lat_cnt_q;
    beat_d            = beat_q;
    base_d            = base_q;
    id_d              = id_q;
    we_d              = we_q;
    last_conflict_d_d = last_conflict_d_q;
    case (state_q)
      MEMRSP_ST_IDLE: begin
        if (w_grant_d || w_grant_i) begin
          base_d    = w_grant_d ? w_d_line : w_i_line;
          id_d      = w_grant_d ? RSP_ID_D : RSP_ID_I;
          we_d      = w_grant_d && bus.d_req_we;
          lat_cnt_d = LAT_LOAD;
          state_d   = MEMRSP_ST_LAT;
          if (w_both) begin
            last_conflict_d_d = w_grant_d;
          end
        end
      end
      MEMRSP_ST_LAT: begin
        if (lat_cnt_q == '0) begin
          beat_d  = '0;
          state_d = we_q ? MEMRSP_ST_WR_BURST : MEMRSP_ST_RD_BURST;
        end else begin
          lat_cnt_d = lat_cnt_q - CW'(1);
        end
      end
      MEMRSP_ST_RD_BURST: begin
        beat_d = beat_q + LW'(1);
        if (beat_q == LAST_BEAT) begin
          state_d = MEMRSP_ST_IDLE;
        end
      end
      MEMRSP_ST_WR_BURST: begin
        if (bus.d_wdata_valid) begin
          beat_d = beat_q + LW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = MEMRSP_ST_WR_DONE;
          end
        end
      end
      MEMRSP_ST_WR_DONE: state_d = MEMRSP_ST_IDLE;
      default:           state_d = MEMRSP_ST_IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so beat k+1 is addressed during beat k.
  assign w_beat_ext = AW'(beat_q);
  assign w_mem_we   = w_wr_burst && bus.d_wdata_valid;
  always_comb begin
    w_mem_addr = base_q + w_beat_ext + AW'(1);
    if (w_wr_burst) begin
      w_mem_addr = base_q + w_beat_ext;
    end else if (state_q == MEMRSP_ST_LAT) begin
      w_mem_addr = base_q;
    end
  end

  always_comb begin
    rsp_valid_d = (w_lat_done && !we_q) ||
                  ((state_q == MEMRSP_ST_RD_BURST) && (beat_q != LAST_BEAT));
    rsp_last_d  = (state_q == MEMRSP_ST_RD_BURST) && (beat_q == PENULT_BEAT);
    rsp_id_d    = rsp_valid_d ? id_q : RSP_ID_I;
    wr_done_d   = w_mem_we && (beat_q == LAST_BEAT);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q           <= MEMRSP_ST_IDLE;
      lat_cnt_q         <= '0;
      beat_q            <= '0;
      base_q            <= '0;
      id_q              <= RSP_ID_I;
      we_q              <= 1'b0;
      last_conflict_d_q <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= RSP_ID_I;
      rsp_last_q        <= 1'b0;
      wr_done_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      lat_cnt_q         <= lat_cnt_d;
      beat_q            <= beat_d;
      base_q            <= base_d;
      id_q              <= id_d;
      we_q              <= we_d;
      last_conflict_d_q <= last_conflict_d_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_id_q          <= rsp_id_d;
      rsp_last_q        <= rsp_last_d;
      wr_done_q         <= wr_done_d;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (DATA_W),
    .ADDR_BITS   (AW)
  ) u_mem (
    .clk     (Clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (bus.d_wdata),
    .o_rdata (w_rdata)
  );

  // Storage has no reset, so the data bus is masked outside valid beats.
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_valid_q ? w_rdata : '0;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_last  = rsp_last_q;
  assign bus.o_wr_done   = wr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_line_responder
// Brief   : Directed bench with a cycle-level reference model of the responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_line_responder;
  import mem_line_responder_pkg::*;

  localparam int LAT   = 3;
  localparam int LINE  = 4;
  localparam int DEPTH = 1024;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  mem_line_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_line_responder #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LINE), .LATENCY(LAT), .DEPTH_WORDS(DEPTH)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Reference model: transaction timing from acceptance cycle plus a word array.
  logic [31:0] mm [DEPTH];
  int   m_phase = 0;
  int   m_base, m_start, m_cnt, m_done_at;
  logic m_id;
  logic m_flag = 1'b0;

  always @(negedge Clk) begin : model
    logic e_ir, e_dr, e_wr, e_v, e_last, e_id, e_done, wd;
    logic [31:0] e_data, a;
    int k;
    e_ir = 0; e_dr = 0; e_wr = 0; e_v = 0; e_last = 0; e_id = 0; e_done = 0;
    e_data = 0;
    if (Rst) begin
      m_phase = 0;
      m_flag  = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.i_req_valid || bus.d_req_valid) begin
          if (bus.i_req_valid && bus.d_req_valid) wd = !m_flag;
          else wd = bus.d_req_valid;
          e_dr = wd;
          e_ir = !wd;
          if (bus.i_req_valid && bus.d_req_valid) m_flag = wd;
          a = wd ? bus.d_req_addr : bus.i_req_addr;
          m_base = (int'((a / 4) % DEPTH) / LINE) * LINE;
          m_id = wd;
          m_phase = (wd && bus.d_req_we) ? 2 : 1;
          m_start = cyc + LAT + 1;
          m_cnt = 0;
          m_done_at = -1;
        end
        1: if (cyc >= m_start) begin
          k = cyc - m_start;
          e_v = 1;
          e_data = mm[(m_base + k) % DEPTH];
          e_id = m_id;
          e_last = (k == LINE - 1);
          if (e_last) m_phase = 0;
        end
        2: if (m_done_at >= 0) begin
          e_done = 1;
          m_phase = 0;
        end else if (cyc >= m_start) begin
          e_wr = 1;
          if (bus.d_wdata_valid) begin
            mm[(m_base + m_cnt) % DEPTH] = bus.d_wdata;
            m_cnt++;
            if (m_cnt == LINE) m_done_at = cyc + 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
    chk("m_i_ready", {31'b0, bus.o_i_req_ready}, {31'b0, e_ir});
    chk("m_d_ready", {31'b0, bus.o_d_req_ready}, {31'b0, e_dr});
    chk("m_wdata_ready", {31'b0, bus.o_d_wdata_ready}, {31'b0, e_wr});
    chk("m_rsp_valid", {31'b0, bus.o_rsp_valid}, {31'b0, e_v});
    chk("m_rsp_last", {31'b0, bus.o_rsp_last}, {31'b0, e_last});
    chk("m_rsp_id", {31'b0, bus.o_rsp_id}, {31'b0, e_id});
    chk("m_wr_done", {31'b0, bus.o_wr_done}, {31'b0, e_done});
    if (e_v || Rst) chk("m_rsp_data", bus.o_rsp_data, e_data);
  end

  task automatic wait_accept(input bit is_d, output int acc);
    acc = -1;
    for (int g = 0; g < 60; g++) begin
      @(negedge Clk);
      if (is_d ? bus.o_d_req_ready : bus.o_i_req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout is_d=%0d got=none exp=ready", is_d);
    end
  endtask

  task automatic read_line(input bit is_d, input logic [31:0] addr,
                           input logic [31:0] d0, input string nm);
    int acc;
    @(posedge Clk); #1;
    if (is_d) begin
      bus.d_req_valid = 1; bus.d_req_addr = addr; bus.d_req_we = 0;
    end else begin
      bus.i_req_valid = 1; bus.i_req_addr = addr;
    end
    wait_accept(is_d, acc);
    @(posedge Clk); #1;
    bus.i_req_valid = 0;
    bus.d_req_valid = 0;
    if (acc >= 0) begin
      do @(negedge Clk); while (cyc < acc + LAT);
      chk({nm, "_pre"}, {31'b0, bus.o_rsp_valid}, 32'd0);
      for (int k = 0; k < LINE; k++) begin
        @(negedge Clk);
        chk({nm, "_valid"}, {31'b0, bus.o_rsp_valid}, 32'd1);
        chk({nm, "_data"}, bus.o_rsp_data, d0 + 32'(k));
        chk({nm, "_last"}, {31'b0, bus.o_rsp_last}, {31'b0, k == LINE - 1});
        chk({nm, "_id"}, {31'b0, bus.o_rsp_id}, {31'b0, is_d});
      end
      @(negedge Clk);
      chk({nm, "_post"}, {31'b0, bus.o_rsp_valid}, 32'd0);
    end
  endtask

  task automatic d_write(input logic [31:0] addr, input logic [31:0] d0,
                         input int gap_after, input int gap_len,
                         output int acc, output int done);
    int b, gap, guard;
    bit fire;
    done = -1;
    @(posedge Clk); #1;
    bus.d_req_valid = 1; bus.d_req_addr = addr; bus.d_req_we = 1;
    wait_accept(1'b1, acc);
    @(posedge Clk); #1;
    bus.d_req_valid = 0; bus.d_req_we = 0;
    if (acc < 0) return;
    b = 0; gap = 0; guard = 0;
    bus.d_wdata_valid = 1; bus.d_wdata = d0;
    while (b < LINE && guard < 60) begin
      @(negedge Clk);
      guard++;
      fire = bus.d_wdata_valid && bus.o_d_wdata_ready;
      @(posedge Clk); #1;
      if (fire) begin
        b++;
        if (b == gap_after + 1) gap = gap_len;
      end else if (gap > 0) begin
        gap--;
      end
      bus.d_wdata_valid = (b < LINE) && (gap == 0);
      bus.d_wdata = d0 + 32'(b);
    end
    bus.d_wdata_valid = 0;
    if (b < LINE) begin
      n_checks++;
      n_errors++;
      $display("FAIL wdata_timeout got=%0d exp=%0d beats", b, LINE);
      return;
    end
    for (int g = 0; g < 20; g++) begin
      @(negedge Clk);
      if (bus.o_wr_done) begin
        done = cyc;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    int acc, done;
    bit win [4];
    bus.i_req_valid = 1; bus.i_req_addr = 32'h14;
    bus.d_req_valid = 0; bus.d_req_addr = 0; bus.d_req_we = 0;
    bus.d_wdata = 0; bus.d_wdata_valid = 0;
    repeat (3) @(negedge Clk);
    chk("rst_i_ready", {31'b0, bus.o_i_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    chk("rst_wr_done", {31'b0, bus.o_wr_done}, 32'd0);
    chk("rst_rsp_data", bus.o_rsp_data, 32'd0);
    bus.i_req_valid = 0;
    @(posedge Clk); #1;
    Rst = 0;

    // Words 4..7 preloaded through a write-back, then refilled by I.
    d_write(32'h10, 32'hA0, -1, 0, acc, done);
    chk("wb10_done_lat", 32'(done - acc), 32'd8);
    read_line(1'b0, 32'h14, 32'hA0, "i_0x14");

    d_write(32'h40, 32'h11, -1, 0, acc, done);
    chk("wb40_done_lat", 32'(done - acc), 32'd8);
    read_line(1'b1, 32'h48, 32'h11, "d_0x48");

    // Three conflicts in a row, then the leftover I request alone.
    @(posedge Clk); #1;
    bus.i_req_valid = 1; bus.i_req_addr = 32'h14;
    bus.d_req_valid = 1; bus.d_req_addr = 32'h40; bus.d_req_we = 0;
    for (int k = 0; k < 4; k++) begin
      win[k] = 0;
      for (int g = 0; g < 40; g++) begin
        @(negedge Clk);
        if (bus.o_i_req_ready || bus.o_d_req_ready) break;
      end
      win[k] = bus.o_d_req_ready;
      chk("arb_some_ready", {31'b0, bus.o_i_req_ready || bus.o_d_req_ready}, 32'd1);
      @(posedge Clk); #1;
      if (win[k]) bus.d_req_valid = (k < 2);
      else bus.i_req_valid = (k < 2);
    end
    chk("arb_win0", {31'b0, win[0]}, 32'd1);
    chk("arb_win1", {31'b0, win[1]}, 32'd0);
    chk("arb_win2", {31'b0, win[2]}, 32'd1);
    chk("arb_win3", {31'b0, win[3]}, 32'd0);
    bus.i_req_valid = 0; bus.d_req_valid = 0;
    repeat (12) @(negedge Clk);

    d_write(32'h80, 32'h21, 1, 2, acc, done);
    chk("wb80_gap_done_lat", 32'(done - acc), 32'd10);
    read_line(1'b0, 32'h8C, 32'h21, "i_0x80");

    // Reset during beat 2 of a refill.
    @(posedge Clk); #1;
    bus.i_req_valid = 1; bus.i_req_addr = 32'h80;
    wait_accept(1'b0, acc);
    @(posedge Clk); #1;
    bus.i_req_valid = 0;
    do @(negedge Clk); while (cyc < acc + LAT + 2);
    chk("rst_pre_beat1", {31'b0, bus.o_rsp_valid}, 32'd1);
    @(posedge Clk); #2;
    Rst = 1;
    #1;
    chk("rst_async_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
    @(negedge Clk);
    chk("rst_mid_last", {31'b0, bus.o_rsp_last}, 32'd0);
    @(posedge Clk); #1;
    Rst = 0;
    repeat (6) begin
      @(negedge Clk);
      chk("rst_no_last", {31'b0, bus.o_rsp_last}, 32'd0);
    end
    read_line(1'b0, 32'h80, 32'h21, "i_after_rst");

    // Top line of storage and wrap of the index back to word 0.
    d_write(32'hFF0, 32'hC0, -1, 0, acc, done);
    d_write(32'h000, 32'hD0, -1, 0, acc, done);
    read_line(1'b0, 32'hFFC, 32'hC0, "i_0xFFC");
    read_line(1'b1, 32'h1000, 32'hD0, "d_wrap");

    repeat (4) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
